jpu_uart_echo_top: RTL and testbench

- FPGA-top-level stand-in for the JPU implementation wrapper.
- Contains a UART receiver, a UART transmitter and a small echo/control engine:
  - every byte received on uart_txd_in is echoed back on uart_rxd_out;
  - a received newline (0x0A) halts the block after its echo completes.
- Status is exported on status_led; bit 1 is the halt indicator that the system bench watches to end simulation.

---
 rtl/jpu_uart_echo_top.sv | 223 ++++++++++++++++++++++
 tb/tb_jpu_uart_echo_top.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jpu_uart_echo_top.sv
// UART echo top: 8N1 receiver, echo FIFO with optional upper-casing, transmitter,
// and halt-on-newline control exported on status_led.
module jpu_uart_echo_top #(
  parameter int unsigned UART_DIVIDE = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] user_btn,
  input  logic [3:0] user_sw,
  input  logic       uart_txd_in,
  output logic [7:0] status_led,
  output logic       uart_rxd_out
);

  localparam logic [31:0] DIV  = 32'(UART_DIVIDE);
  localparam logic [31:0] HALF = DIV >> 1;
  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam int          CW   = AW + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic        rx_s1, rx_s2, rx_prev;
  logic [31:0] rx_cnt, tx_cnt;
  logic [2:0]  rx_bit, tx_bit;
  logic [7:0]  rx_shift, rx_data, tx_shift, tx_byte, echo_byte;
  logic        rx_valid, rx_ferr;
  logic        tx_line, tx_done_nl;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;
  logic          running, halted, ferr_flag, ovf_flag;
  logic [2:0]    occ;

  logic unused_inputs;
  assign unused_inputs = ^{user_btn[3:1], user_sw[3:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
    end else begin
      rx_s1   <= uart_txd_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver: a mid-start resample filters glitches; stop is checked at its centre.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF - 32'd1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV - 32'd1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV - 32'd1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    echo_byte = rx_data;
    if (user_sw[0] && rx_data >= 8'h61 && rx_data <= 8'h7A) echo_byte = rx_data - 8'h20;
  end

  assign full       = (count == CW'(FIFO_DEPTH));
  assign push       = rx_valid && !halted && !full;
  assign pop        = (tx_state == TX_IDLE) && (count != '0) && !halted;
  assign tx_done_nl = (tx_state == TX_STOP) && (tx_cnt == DIV - 32'd1) && (tx_byte == 8'h0A);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= echo_byte;
  end

  // Flag clears come first so a same-cycle set event still wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
      ferr_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (user_btn[0]) begin
        halted    <= 1'b0;
        ferr_flag <= 1'b0;
        ovf_flag  <= 1'b0;
      end
      if (rx_ferr) ferr_flag <= 1'b1;
      if (rx_valid && !halted && full) ovf_flag <= 1'b1;
      if (tx_done_nl) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_byte  <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (pop) begin
            tx_byte  <= mem[rd_ptr];
            tx_shift <= mem[rd_ptr];
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV - 32'd1) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 32'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV - 32'd1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 32'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV - 32'd1) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 32'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    occ = 3'(count);
    if (32'(count) > 32'd7) occ = 3'd7;
  end

  assign status_led   = {occ, tx_state != TX_IDLE, ovf_flag, ferr_flag, halted, running};
  assign uart_rxd_out = tx_line;

endmodule

// File: tb/tb_jpu_uart_echo_top.sv
// Bench for jpu_uart_echo_top: drives serial frames, decodes the echo line and
// compares against a queue-based model of what must come back.
module tb_jpu_uart_echo_top;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] user_btn = 4'b0;
  logic [3:0] user_sw = 4'b0;
  logic       uart_txd_in = 1'b1;
  logic [7:0] status_led;
  logic       uart_rxd_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_send_start = 0;
  int last_echo_start = 0;
  int peak_occ = 0;
  bit model_halted = 1'b0;
  bit ovf_mode = 1'b0;
  bit dec_busy = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] got_q[$];

  jpu_uart_echo_top #(.UART_DIVIDE(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .user_btn     (user_btn),
    .user_sw      (user_sw),
    .uart_txd_in  (uart_txd_in),
    .status_led   (status_led),
    .uart_rxd_out (uart_rxd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (ovf_mode && int'(status_led[7:5]) > peak_occ) peak_occ = int'(status_led[7:5]);

  function automatic logic [7:0] echo_of(input logic [7:0] b, input logic sw);
    if (sw && b >= "a" && b <= "z") return b - 8'd32;
    return b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // The echo is recorded as expected once the stop bit starts, before it can appear.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input int stop_len);
    logic [7:0] e;
    last_send_start = cyc;
    uart_txd_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (stop_val) begin
      e = echo_of(b, user_sw[0]);
      if (ovf_mode) sent_q.push_back(e);
      else if (!model_halted) begin
        exp_q.push_back(e);
        if (e == 8'h0A) model_halted = 1'b1;
      end
    end
    uart_txd_in = stop_val;
    repeat (stop_len) @(negedge clk);
    uart_txd_in = 1'b1;
  endtask

  task automatic pulseButton();
    user_btn[0] = 1'b1;
    @(negedge clk);
    user_btn[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dec_busy && status_led[4] == 1'b0 && status_led[7:5] == 3'd0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_within_budget", int'(done), 1);
    repeat (2 * DIV) @(negedge clk);
  endtask

  initial begin : decoder
    logic prev_line;
    logic [7:0] b;
    logic s_start, s_stop;
    int n0;
    prev_line = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev_line && !uart_rxd_out) begin
        dec_busy = 1'b1;
        n0 = cyc;
        last_echo_start = n0;
        repeat (DIV / 2 - 1) @(negedge clk);
        s_start = uart_rxd_out;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_rxd_out;
        end
        repeat (DIV) @(negedge clk);
        s_stop = uart_rxd_out;
        checkOutput("echo_frame_shape", int'({s_start, s_stop}), 1);
        if (ovf_mode) got_q.push_back(b);
        else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_echo: got 0x%02h, expected no frame", b);
        end else checkOutput("echo_byte", int'(b), int'(exp_q.pop_front()));
        if (!ovf_mode && b == 8'h0A) begin
          repeat (DIV / 2) @(negedge clk);
          checkOutput("halt_before_stop_end", int'(status_led[1]), 0);
          repeat (2) @(negedge clk);
          checkOutput("halt_after_stop_end", int'(status_led[1]), 1);
        end
        dec_busy = 1'b0;
      end
      prev_line = uart_rxd_out;
    end
  end

  initial begin : main
    int lat, idx, drops;
    bit found;
    logic [7:0] b;

    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_status", int'(status_led), 8'h00);
    checkOutput("reset_line", int'(uart_rxd_out), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("running_after_release", int'(status_led), 8'h01);
    repeat (1000) @(negedge clk);
    checkOutput("quiet_status", int'(status_led), 8'h01);

    applyStimulus(8'h41, 1'b1, DIV);
    drain(2000);
    lat = last_echo_start - last_send_start;
    vectors++;
    if (lat < 9 * DIV + DIV / 2 || lat > 9 * DIV + DIV / 2 + 6) begin
      miscompares++;
      $display("[TB] FAIL echo_latency: got %0d clk, expected %0d..%0d", lat, 9 * DIV + DIV / 2, 9 * DIV + DIV / 2 + 6);
    end
    checkOutput("no_halt_after_A", int'(status_led), 8'h01);

    applyStimulus("A", 1'b1, DIV);
    applyStimulus("q", 1'b1, DIV);
    applyStimulus(8'h0A, 1'b1, DIV);
    drain(4000);
    checkOutput("halted_status", int'(status_led), 8'h03);
    applyStimulus("Z", 1'b1, DIV);
    repeat (12 * DIV) @(negedge clk);
    checkOutput("halted_ignores_input", int'(status_led), 8'h03);
    pulseButton();
    model_halted = 1'b0;
    checkOutput("halt_cleared", int'(status_led), 8'h01);

    user_sw = 4'b0001;
    applyStimulus("q", 1'b1, DIV);
    applyStimulus("5", 1'b1, DIV);
    drain(3000);
    user_sw = 4'b0000;
    checkOutput("case_convert_status", int'(status_led), 8'h01);

    applyStimulus(8'h55, 1'b0, DIV);
    repeat (4 * DIV) @(negedge clk);
    checkOutput("framing_error_flag", int'(status_led), 8'h05);
    pulseButton();
    checkOutput("framing_error_cleared", int'(status_led), 8'h01);

    for (int batch = 0; batch < 2; batch++) begin
      user_sw = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      for (int n = 0; n < 12; n++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0A) b = 8'h0B;
        applyStimulus(b, 1'b1, DIV);
      end
      drain(8000);
      checkOutput("random_batch_status", int'(status_led), 8'h01);
    end

    // Short stop bits let frames arrive slightly faster than the echo can drain.
    user_sw = {3'b0, 1'($urandom_range(0, 1))};
    ovf_mode = 1'b1;
    peak_occ = 0;
    for (int n = 0; n < 240; n++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h0A) b = 8'h0B;
      applyStimulus(b, 1'b1, DIV / 2 + 4);
    end
    drain(3000);
    ovf_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) checkOutput("ovf_early_byte", int'(got_q[i]), int'(sent_q[i]));
      else checkOutput("ovf_early_byte_present", 0, 1);
    end
    idx = 0;
    foreach (got_q[g]) begin
      found = 1'b0;
      while (idx < sent_q.size()) begin
        if (sent_q[idx] == got_q[g]) begin
          found = 1'b1;
          idx++;
          break;
        end
        idx++;
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("[TB] FAIL ovf_order: got 0x%02h at echo %0d, expected a later sent byte", got_q[g], g);
      end
    end
    drops = sent_q.size() - got_q.size();
    vectors++;
    if (drops < 1) begin
      miscompares++;
      $display("[TB] FAIL ovf_drops: got %0d dropped, expected at least 1", drops);
    end
    checkOutput("ovf_peak_occupancy", peak_occ, DEPTH);
    checkOutput("ovf_status", int'(status_led), 8'h09);
    pulseButton();
    checkOutput("ovf_cleared", int'(status_led), 8'h01);

    checkOutput("expectations_consumed", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
